sha256_block_feeder: RTL and testbench

//   Host-side front end of the SHA-256 core; the producer side of the core's first_block/last_block interface.
//   - Accepts a message as a stream of 32-bit big-endian words.
//   - Buffers 16 words per block and applies SHA-256 padding (0x80, zero fill, 64-bit bit-length).
//   - Launches each 512-bit block into the core with the first_block / last_block / word sequence.
//   - Waits for core_busy to drop before launching the next block.

---
 rtl/sha256_block_feeder.sv | 181 ++++++++++++++++++
 tb/tb_sha256_block_feeder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_feeder.sv
// SHA-256 host front end: packs a big-endian word stream into 512-bit blocks,
// applies message padding and replays each block to the core, one word per cycle.
module sha256_block_feeder #(
  parameter int LEN_W    = 64,
  parameter int IDLE_GAP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [2:0]  in_bytes,
  output logic        first_block,
  output logic        last_block,
  output logic [31:0] msg_word,
  output logic        msg_word_valid,
  output logic        chain_init,
  output logic        final_block,
  input  logic        core_busy,
  output logic        busy
);
  localparam int GW = $clog2(IDLE_GAP + 1) + 1;

  typedef enum logic [2:0] {IDLE, FILL, PAD, LAUNCH, SEND, WAIT} state_t;

  state_t            state;
  logic [31:0]       blk [16];
  logic [3:0]        idx, pidx;
  logic [4:0]        sidx;
  logic [GW-1:0]     gcnt;
  logic [LEN_W-1:0]  len;
  logic [63:0]       len64;
  logic              first_msg, need_80, len_here, extra, fin_sent;
  logic [2:0]        nb;
  logic [31:0]       din, pad_word;
  logic              take, fits;

  // The 0x80 marker is merged into a partial final word at accept time,
  // so padding only ever has to write whole words.
  always_comb begin
    nb = 3'd4;
    if (in_last && in_bytes < 3'd4) nb = in_bytes;
    case (nb)
      3'd0:    din = 32'h8000_0000;
      3'd1:    din = {in_data[31:24], 24'h80_0000};
      3'd2:    din = {in_data[31:16], 16'h8000};
      3'd3:    din = {in_data[31:8], 8'h80};
      default: din = in_data;
    endcase
    fits = (nb == 3'd4) ? (idx <= 4'd12) : (idx <= 4'd13);
    len64 = '0;
    len64[LEN_W-1:0] = len;
    pad_word = need_80 ? 32'h8000_0000 : 32'h0;
    if (len_here && pidx == 4'd14) pad_word = len64[63:32];
    if (len_here && pidx == 4'd15) pad_word = len64[31:0];
  end

  assign take = in_valid && in_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      in_ready <= 1'b0;
      first_block <= 1'b0;
      last_block <= 1'b0;
      msg_word <= '0;
      msg_word_valid <= 1'b0;
      chain_init <= 1'b0;
      final_block <= 1'b0;
      idx <= '0;
      pidx <= '0;
      sidx <= '0;
      gcnt <= '0;
      len <= '0;
      first_msg <= 1'b1;
      need_80 <= 1'b0;
      len_here <= 1'b0;
      extra <= 1'b0;
      fin_sent <= 1'b0;
      for (int i = 0; i < 16; i++) blk[i] <= '0;
    end else begin
      first_block <= 1'b0;
      last_block <= 1'b0;
      chain_init <= 1'b0;
      final_block <= 1'b0;
      case (state)
        IDLE, FILL: begin
          in_ready <= 1'b1;
          if (take) begin
            blk[idx] <= din;
            len <= len + (LEN_W'(nb) << 3);
            if (in_last) begin
              in_ready <= 1'b0;
              need_80 <= (nb == 3'd4);
              len_here <= fits;
              extra <= !fits;
              if (idx == 4'd15) begin
                state <= LAUNCH;
                first_block <= 1'b1;
                chain_init <= first_msg;
                fin_sent <= 1'b0;
              end else begin
                state <= PAD;
                pidx <= idx + 4'd1;
              end
            end else if (idx == 4'd15) begin
              in_ready <= 1'b0;
              extra <= 1'b0;
              idx <= '0;
              state <= LAUNCH;
              first_block <= 1'b1;
              chain_init <= first_msg;
              fin_sent <= 1'b0;
            end else begin
              idx <= idx + 4'd1;
              state <= FILL;
            end
          end
        end
        PAD: begin
          blk[pidx] <= pad_word;
          need_80 <= 1'b0;
          pidx <= pidx + 4'd1;
          if (pidx == 4'd15) begin
            state <= LAUNCH;
            first_block <= 1'b1;
            chain_init <= first_msg;
            final_block <= len_here;
            fin_sent <= len_here;
          end
        end
        LAUNCH: begin
          state <= SEND;
          first_msg <= 1'b0;
          msg_word <= blk[0];
          msg_word_valid <= 1'b1;
          last_block <= 1'b1;
          sidx <= 5'd1;
        end
        SEND: begin
          if (sidx == 5'd16) begin
            msg_word <= '0;
            msg_word_valid <= 1'b0;
            gcnt <= '0;
            state <= WAIT;
          end else begin
            msg_word <= blk[sidx[3:0]];
            sidx <= sidx + 5'd1;
          end
        end
        WAIT: begin
          if (gcnt < GW'(IDLE_GAP)) gcnt <= gcnt + 1'b1;
          else if (!core_busy) begin
            if (fin_sent) begin
              state <= IDLE;
              len <= '0;
              first_msg <= 1'b1;
              in_ready <= 1'b1;
              idx <= '0;
              extra <= 1'b0;
              fin_sent <= 1'b0;
            end else if (extra) begin
              // length did not fit: pad a trailing block holding only marker/length
              state <= PAD;
              pidx <= '0;
              len_here <= 1'b1;
              extra <= 1'b0;
            end else begin
              state <= FILL;
              idx <= '0;
              in_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_block_feeder.sv
// Randomized bench for sha256_block_feeder; expected blocks come from plain
// SHA-256 byte-level padding of each generated message.
module tb_sha256_block_feeder;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic [2:0]  in_bytes;
  logic        first_block, last_block, msg_word_valid, chain_init, final_block;
  logic [31:0] msg_word;
  logic        core_busy, busy;

  typedef struct {
    logic [15:0][31:0] w;
    bit ci;
    bit fb;
  } blk_t;

  blk_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   busy_hold = 0;
  bit   mon_en = 1'b1;

  always #5 clk = ~clk;

  sha256_block_feeder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
    .first_block(first_block), .last_block(last_block), .msg_word(msg_word),
    .msg_word_valid(msg_word_valid), .chain_init(chain_init), .final_block(final_block),
    .core_busy(core_busy), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Standard SHA-256 padding on the byte stream, split into 64-byte blocks.
  task automatic push_expected(input byte unsigned bq [$]);
    byte unsigned p [$];
    logic [63:0]  bl;
    blk_t         e;
    int           nblk;
    p = bq;
    bl = 64'(bq.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < 16; j++)
        e.w[j] = {p[64*b+4*j], p[64*b+4*j+1], p[64*b+4*j+2], p[64*b+4*j+3]};
      e.ci = (b == 0);
      e.fb = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_msg(input int nw, input int lb, input bit abc, input int hold, input bit push);
    logic [31:0]  w [$];
    byte unsigned bq [$];
    logic [31:0]  d;
    int           nbv, t;
    for (int i = 0; i < nw; i++) begin
      d = abc ? 32'h6162_6300 : $urandom;
      nbv = (i == nw - 1) ? lb : 4;
      w.push_back(d);
      for (int j = 0; j < nbv; j++) bq.push_back(d[31-8*j -: 8]);
    end
    if (push) push_expected(bq);
    busy_hold = hold;
    for (int i = 0; i < nw; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = w[i];
      in_last  = (i == nw - 1);
      in_bytes = (i == nw - 1) ? 3'(lb) : 3'($urandom_range(0, 7));
      t = 0;
      while (!in_ready && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 3000) begin
        chk("ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(exp_q.size()), 0);
    repeat (40) @(negedge clk);
  endtask

  // Block monitor: launch qualifiers, then 16 words on fixed timing.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && first_block) begin
        blk_t e;
        if (exp_q.size() == 0) chk("unexpected_block", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("chain_init", chain_init, e.ci);
          chk("final_block", final_block, e.fb);
          chk("ready_at_launch", in_ready, 0);
          for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("word_valid", msg_word_valid, 1);
            chk("last_block", last_block, (i == 0));
            chk("ready_in_send", in_ready, 0);
            chk($sformatf("word%0d", i), msg_word, e.w[i]);
          end
          @(negedge clk);
          chk("word_off", {msg_word_valid, msg_word}, 0);
        end
      end
    end
  end

  // Core model: busy from launch through the words plus a programmable hold.
  initial begin
    core_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (first_block) begin
        core_busy = 1'b1;
        repeat (16) @(negedge clk);
        for (int i = 0; i < busy_hold; i++) begin
          @(negedge clk);
          if (mon_en) begin
            chk("hold_no_launch", first_block, 0);
            chk("hold_ready", in_ready, 0);
          end
        end
        core_busy = 1'b0;
      end
    end
  end

  initial begin
    int t;
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    in_bytes = '0;
    #1;
    chk("reset_outs", {in_ready, first_block, last_block, msg_word, msg_word_valid,
                       chain_init, final_block, busy}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    chk("idle_busy", busy, 0);

    send_msg(1, 0, 1'b0, 2, 1'b1);    // empty message
    send_msg(1, 3, 1'b1, 1, 1'b1);    // "abc"
    send_msg(14, 4, 1'b0, 80, 1'b1);  // length spills into a second block, long core hold
    send_msg(17, 1, 0, 3, 1'b1);      // full block then one byte
    drain();
    repeat (25) send_msg($urandom_range(1, 40), $urandom_range(0, 4), 1'b0, $urandom_range(0, 5), 1'b1);
    drain();

    // Abort mid-SEND, then verify a fresh message restarts the chain.
    mon_en = 1'b0;
    send_msg(3, 4, 1'b0, 2, 1'b0);
    t = 0;
    while (!first_block && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("abort_launch_seen", first_block, 1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_outs", {in_ready, first_block, last_block, msg_word, msg_word_valid,
                             chain_init, final_block, busy}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (150) @(negedge clk);
    mon_en = 1'b1;
    send_msg(1, 3, 1'b1, 0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
